// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - command sequencer driving a 16-bit ALU from a small register file
// Loads complete in IDLE at one per clock; ALU ops take IDLE -> EXEC -> RESP.
module alu_op_sequencer #(
  parameter int WIDTH = 16,
  parameter int NREGS = 4,
  parameter int RAW   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_load,
  input  logic [3:0]       cmd_select,
  input  logic             cmd_mode,
  input  logic             cmd_use_cf,
  input  logic [RAW-1:0]   cmd_srca,
  input  logic [RAW-1:0]   cmd_srcb,
  input  logic [RAW-1:0]   cmd_dst,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic [WIDTH-1:0] alu_in_a,
  output logic [WIDTH-1:0] alu_in_b,
  output logic [3:0]       alu_select,
  output logic             alu_mode,
  output logic             alu_carry_in,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout,
  input  logic             alu_cmp,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_carry,
  output logic             rsp_compare,
  output logic             carry_flag
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] rf [NREGS];
  logic [3:0]       op_select;
  logic             op_mode;
  logic             op_use_cf;
  logic [RAW-1:0]   op_srca;
  logic [RAW-1:0]   op_srcb;
  logic [RAW-1:0]   op_dst;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
      carry_flag  <= 1'b0;
      rsp_data    <= '0;
      rsp_carry   <= 1'b0;
      rsp_compare <= 1'b0;
      op_select   <= '0;
      op_mode     <= 1'b0;
      op_use_cf   <= 1'b0;
      op_srca     <= '0;
      op_srcb     <= '0;
      op_dst      <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (cmd_load) begin
              rf[cmd_dst] <= cmd_imm;
            end else begin
              op_select <= cmd_select;
              op_mode   <= cmd_mode;
              op_use_cf <= cmd_use_cf;
              op_srca   <= cmd_srca;
              op_srcb   <= cmd_srcb;
              op_dst    <= cmd_dst;
            end
          end
        end
        EXEC: begin
          // Sources were presented combinationally this cycle, so dst may alias a source.
          rf[op_dst]  <= alu_result;
          rsp_data    <= alu_result;
          rsp_compare <= alu_cmp;
          carry_flag  <= op_mode & alu_cout;
          rsp_carry   <= op_mode & alu_cout;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx     = state;
    cmd_ready    = 1'b0;
    rsp_valid    = 1'b0;
    alu_in_a     = '0;
    alu_in_b     = '0;
    alu_select   = '0;
    alu_mode     = 1'b0;
    alu_carry_in = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid && !cmd_load) state_nx = EXEC;
      end
      EXEC: begin
        alu_in_a     = rf[op_srca];
        alu_in_b     = rf[op_srcb];
        alu_select   = op_select;
        alu_mode     = op_mode;
        alu_carry_in = op_use_cf & carry_flag;
        state_nx     = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - scoreboard bench for alu_op_sequencer with a behavioural ALU stub
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_load = 1'b0;
  logic [3:0]  cmd_select = '0;
  logic        cmd_mode = 1'b0;
  logic        cmd_use_cf = 1'b0;
  logic [1:0]  cmd_srca = '0, cmd_srcb = '0, cmd_dst = '0;
  logic [15:0] cmd_imm = '0;
  logic [15:0] alu_in_a, alu_in_b, alu_result, rsp_data;
  logic [3:0]  alu_select;
  logic        alu_mode, alu_carry_in, alu_cout, alu_cmp;
  logic        rsp_valid, rsp_carry, rsp_compare, carry_flag;
  logic        rsp_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  int rdy_mode = 1;  // 0 random, 1 hold low, 2 hold high

  typedef struct {
    logic [15:0] data;
    logic        carry;
    logic        cmp;
  } exp_t;
  exp_t        sb_q[$];
  logic [15:0] m_rf [4];
  logic        m_cf;

  always #5 clk = ~clk;

  alu_op_sequencer #(.WIDTH(16), .NREGS(4), .RAW(2)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_load(cmd_load), .cmd_select(cmd_select), .cmd_mode(cmd_mode),
    .cmd_use_cf(cmd_use_cf), .cmd_srca(cmd_srca), .cmd_srcb(cmd_srcb),
    .cmd_dst(cmd_dst), .cmd_imm(cmd_imm), .alu_in_a(alu_in_a), .alu_in_b(alu_in_b),
    .alu_select(alu_select), .alu_mode(alu_mode), .alu_carry_in(alu_carry_in),
    .alu_result(alu_result), .alu_cout(alu_cout), .alu_cmp(alu_cmp),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_carry(rsp_carry), .rsp_compare(rsp_compare), .carry_flag(carry_flag)
  );

  // ALU stub: a few 74181-style functions, carry_out meaningful in arithmetic mode
  function automatic logic [16:0] alu_f(input logic [3:0] s, input logic m,
                                        input logic [15:0] a, input logic [15:0] b,
                                        input logic ci);
    logic [16:0] r;
    if (m) begin
      case (s)
        4'b0101: r = {1'b0, a | b} + {1'b0, a & ~b} + 17'(ci);
        4'b0110: r = {1'b0, a} + {1'b0, ~b} + 17'(ci);
        default: r = {1'b0, a} + {1'b0, b} + 17'(ci);
      endcase
    end else begin
      case (s)
        4'b0110: r = {1'b0, a ^ b};
        4'b1011: r = {1'b0, a & b};
        4'b1110: r = {1'b0, a | b};
        default: r = {1'b0, ~a};
      endcase
    end
    return r;
  endfunction

  assign {alu_cout, alu_result} = alu_f(alu_select, alu_mode, alu_in_a, alu_in_b, alu_carry_in);
  assign alu_cmp = (alu_in_a == alu_in_b);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #2;
    rsp_ready = (rdy_mode == 2) ? 1'b1 : (rdy_mode == 1) ? 1'b0 : 1'(($urandom % 3) != 0);
  end

  // Monitor: pops one expectation per response handshake
  initial forever begin
    @(negedge clk);
    if (!reset && rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("rsp_data", 32'(rsp_data), 32'(e.data));
        chk("rsp_carry", 32'(rsp_carry), 32'(e.carry));
        chk("rsp_compare", 32'(rsp_compare), 32'(e.cmp));
        chk("carry_flag", 32'(carry_flag), 32'(e.carry));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accept edge (in EXEC for ops)
  task automatic do_cmd(input logic ld, input logic [3:0] sel, input logic md, input logic ucf,
                        input logic [1:0] a, input logic [1:0] b, input logic [1:0] d,
                        input logic [15:0] imm, input bit push);
    int w;
    logic [16:0] r;
    logic        ci;
    exp_t        e;
    cmd_load = ld; cmd_select = sel; cmd_mode = md; cmd_use_cf = ucf;
    cmd_srca = a; cmd_srcb = b; cmd_dst = d; cmd_imm = imm;
    cmd_valid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) chk("cmd_accept_timeout", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    if (ld) begin
      m_rf[d] = imm;
    end else begin
      ci = ucf & m_cf;
      chk("exec_in_a", 32'(alu_in_a), 32'(m_rf[a]));
      chk("exec_in_b", 32'(alu_in_b), 32'(m_rf[b]));
      chk("exec_select", 32'(alu_select), 32'(sel));
      chk("exec_mode", 32'(alu_mode), 32'(md));
      chk("exec_carry_in", 32'(alu_carry_in), 32'(ci));
      if (push) begin
        r = alu_f(sel, md, m_rf[a], m_rf[b], ci);
        e.data = r[15:0];
        e.carry = md & r[16];
        e.cmp = (m_rf[a] == m_rf[b]);
        m_rf[d] = r[15:0];
        m_cf = e.carry;
        sb_q.push_back(e);
      end
    end
  endtask

  // Called in EXEC at posedge+1: checks the response against spec constants, then drains it
  task automatic expect_rsp(input logic [15:0] data, input logic carry, input logic cmp);
    int w;
    @(posedge clk);
    #1;
    chk("dir_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("dir_rsp_data", 32'(rsp_data), 32'(data));
    chk("dir_rsp_carry", 32'(rsp_carry), 32'(carry));
    chk("dir_carry_flag", 32'(carry_flag), 32'(carry));
    chk("dir_rsp_compare", 32'(rsp_compare), 32'(cmp));
    rdy_mode = 2;
    w = 0;
    do begin
      @(posedge clk);
      #1;
      w++;
    end while (rsp_valid && w < 10);
    if (rsp_valid) chk("rsp_drain_timeout", 32'(rsp_valid), 32'd0);
    rdy_mode = 1;
  endtask

  initial begin
    int w;
    for (int i = 0; i < 4; i++) m_rf[i] = '0;
    m_cf = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_carry_flag", 32'(carry_flag), 32'd0);
    chk("reset_alu_outs", {alu_in_a, alu_in_b}, 32'd0);
    chk("reset_alu_ctl", {29'd0, alu_select == 4'd0, alu_mode, alu_carry_in}, 32'd4);
    chk("reset_rsp_data", 32'(rsp_data), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Reset during EXEC abandons the op
    do_cmd(1, 0, 0, 0, 0, 0, 0, 16'h0005, 1);
    do_cmd(1, 0, 0, 0, 0, 0, 1, 16'h0007, 1);
    do_cmd(0, 4'b1001, 1, 0, 0, 1, 0, 0, 0);
    reset = 1'b1;
    #1;
    chk("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midreset_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("midreset_alu_in_a", 32'(alu_in_a), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) m_rf[i] = '0;
    m_cf = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("postreset_rsp_valid", 32'(rsp_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    do_cmd(0, 4'b1001, 1, 0, 0, 1, 2, 0, 1);
    expect_rsp(16'h0000, 1'b0, 1'b1);

    // Back-to-back loads
    do_cmd(1, 0, 0, 0, 0, 0, 0, 16'hFFFF, 1);
    chk("load_b2b_ready", 32'(cmd_ready), 32'd1);
    do_cmd(1, 0, 0, 0, 0, 0, 1, 16'h0001, 1);
    chk("load_b2b_ready2", 32'(cmd_ready), 32'd1);

    do_cmd(0, 4'b0101, 1, 0, 0, 1, 2, 0, 1);
    expect_rsp(16'hFFFD, 1'b1, 1'b0);
    do_cmd(0, 4'b1001, 1, 1, 1, 1, 3, 0, 1);
    expect_rsp(16'h0003, 1'b0, 1'b1);

    do_cmd(1, 0, 0, 0, 0, 0, 0, 16'h00F0, 1);
    do_cmd(1, 0, 0, 0, 0, 0, 1, 16'h0FF0, 1);
    do_cmd(0, 4'b0110, 0, 0, 0, 1, 2, 0, 1);
    expect_rsp(16'h0F00, 1'b0, 1'b0);
    do_cmd(0, 4'b0110, 0, 0, 1, 1, 3, 0, 1);
    expect_rsp(16'h0000, 1'b0, 1'b1);

    // Backpressure with a pending command
    do_cmd(0, 4'b1001, 1, 0, 2, 1, 0, 0, 1);
    @(posedge clk);
    #1;
    cmd_load = 1'b1; cmd_dst = 2'd3; cmd_imm = 16'h1234; cmd_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_data", 32'(rsp_data), 32'h1EF0);
    end
    rdy_mode = 2;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("bp_rsp_drop", 32'(rsp_valid), 32'd0);
    chk("bp_ready_back", 32'(cmd_ready), 32'd1);
    rdy_mode = 1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    m_rf[3] = 16'h1234;
    chk("bp_load_idle", 32'(cmd_ready), 32'd1);
    do_cmd(0, 4'b1011, 0, 0, 3, 3, 1, 0, 1);
    expect_rsp(16'h1234, 1'b0, 1'b1);

    // Randomized traffic
    rdy_mode = 0;
    for (int n = 0; n < 120; n++) begin
      logic [3:0] sels [6];
      sels = '{4'b0101, 4'b0110, 4'b1001, 4'b1011, 4'b1110, 4'b0000};
      if (($urandom % 3) == 0)
        do_cmd(1, 0, 0, 0, 0, 0, 2'($urandom), 16'($urandom), 1);
      else
        do_cmd(0, sels[$urandom_range(0, 5)], 1'($urandom), 1'($urandom),
               2'($urandom), 2'($urandom), 2'($urandom), 0, 1);
    end
    w = 0;
    while (sb_q.size() != 0 && w < 50) begin
      @(posedge clk);
      w++;
    end
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
